fetch_issue: RTL and testbench

FETCH_ISSUE -- requirements
Module: fetch_issue

---
 rtl/fetch_issue.sv | 137 +++++++++++++
 tb/tb_fetch_issue.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_issue.sv
// rtl/fetch_issue.sv - instruction fetch/issue stage with 256x24 program memory.
// Optional feature macro: HAZARD_CHK_EN (rd/rs hazard stall over the last two issues).
module fetch_issue (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pm_we,
  input  logic [7:0]  i_pm_waddr,
  input  logic [23:0] i_pm_wdata,
  input  logic        i_start,
  input  logic [7:0]  i_start_pc,
  input  logic        i_hold,
  output logic [3:0]  o_func,
  output logic [3:0]  o_rd,
  output logic [3:0]  o_rs1,
  output logic [3:0]  o_rs2,
  output logic [7:0]  o_addr,
  output logic        o_issue_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_issue_cnt,
  output logic [15:0] o_stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL, S_HALT} state_t;

  localparam logic [23:0] NOP_WORD = 24'h3000FF;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_pc, w_pc_nxt;
  logic [23:0] r_mem [256];
  logic [23:0] r_out;
  logic        r_valid;
  logic [15:0] r_issue_cnt, r_stall_cnt;
  logic [23:0] w_word;
  logic        w_issue, w_stall, w_hazard, w_wr_ok;

  assign w_word  = r_mem[r_pc];
  assign w_wr_ok = (r_state == S_IDLE) || (r_state == S_HALT);

  // No reset on the array: program contents survive rst.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_pm_we && w_wr_ok) begin
      r_mem[i_pm_waddr] <= i_pm_wdata;
    end
  end

`ifdef HAZARD_CHK_EN
  logic [3:0] r_trk_rd0, r_trk_rd1;
  logic [1:0] r_trk_v;

  always_comb begin
    w_hazard = (r_trk_v[0] && (w_word[15:12] == r_trk_rd0 || w_word[11:8] == r_trk_rd0)) ||
               (r_trk_v[1] && (w_word[15:12] == r_trk_rd1 || w_word[11:8] == r_trk_rd1));
  end

  // Every non-issue cycle shifts an empty slot into the window.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_trk_v   <= 2'b00;
      r_trk_rd0 <= 4'h0;
      r_trk_rd1 <= 4'h0;
    end else begin
      r_trk_v   <= {r_trk_v[0], w_issue};
      r_trk_rd1 <= r_trk_rd0;
      r_trk_rd0 <= w_word[19:16];
    end
  end
`else
  assign w_hazard = 1'b0;
`endif

  // Hold outranks a fetched halt word so the halt waits for hold to drop.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_issue     = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (i_start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = i_start_pc;
        end
      end
      S_RUN, S_STALL: begin
        if (i_hold) begin
          w_state_nxt = S_STALL;
          w_stall     = 1'b1;
        end else if (w_word[23:20] == 4'hF) begin
          w_state_nxt = S_HALT;
        end else if (w_hazard) begin
          w_state_nxt = S_STALL;
          w_stall     = 1'b1;
        end else begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = r_pc + 8'd1;
          w_issue     = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_pc        <= 8'h00;
      r_out       <= NOP_WORD;
      r_valid     <= 1'b0;
      r_issue_cnt <= 16'h0000;
      r_stall_cnt <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_issue;
      r_out   <= w_issue ? w_word : NOP_WORD;
      if (w_issue && r_issue_cnt != 16'hFFFF) begin
        r_issue_cnt <= r_issue_cnt + 16'd1;
      end
      if (w_stall && r_stall_cnt != 16'hFFFF) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign o_func        = r_out[23:20];
  assign o_rd          = r_out[19:16];
  assign o_rs1         = r_out[15:12];
  assign o_rs2         = r_out[11:8];
  assign o_addr        = r_out[7:0];
  assign o_issue_valid = r_valid;
  assign o_busy        = (r_state == S_RUN) || (r_state == S_STALL);
  assign o_done        = (r_state == S_HALT);
  assign o_issue_cnt   = r_issue_cnt;
  assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_fetch_issue.sv
// tb/tb_fetch_issue.sv - scoreboard bench for fetch_issue.
module tb_fetch_issue;

  logic        clk;
  logic        i_rst, i_pm_we, i_start, i_hold;
  logic [7:0]  i_pm_waddr, i_start_pc;
  logic [23:0] i_pm_wdata;
  logic [3:0]  o_func, o_rd, o_rs1, o_rs2;
  logic [7:0]  o_addr;
  logic        o_issue_valid, o_busy, o_done;
  logic [15:0] o_issue_cnt, o_stall_cnt;

  fetch_issue dut (
    .i_clk(clk), .i_rst(i_rst), .i_pm_we(i_pm_we), .i_pm_waddr(i_pm_waddr),
    .i_pm_wdata(i_pm_wdata), .i_start(i_start), .i_start_pc(i_start_pc),
    .i_hold(i_hold), .o_func(o_func), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2),
    .o_addr(o_addr), .o_issue_valid(o_issue_valid), .o_busy(o_busy),
    .o_done(o_done), .o_issue_cnt(o_issue_cnt), .o_stall_cnt(o_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [23:0] sb [$];
  logic [23:0] mem_model [256];
  int          n_iss, gap, max_gap;
  bit          seen;
  int          exp_gap, exp_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] fields();
    return {o_func, o_rd, o_rs1, o_rs2, o_addr};
  endfunction

  task automatic mon();
    logic [23:0] e;
    if (o_issue_valid) begin
      if (seen && gap > max_gap) max_gap = gap;
      seen = 1'b1;
      gap  = 0;
      n_iss++;
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("issue_word", {8'h0, fields()}, {8'h0, e});
      end
    end else begin
      if (seen) gap++;
      check("nop_enc", {8'h0, fields()}, 32'h003000FF);
    end
  endtask

  // Sample at the falling edge, then advance to just after the next rising edge.
  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    sb.delete();
    n_iss = 0; gap = 0; max_gap = 0; seen = 1'b0;
  endtask

  task automatic load(input logic [7:0] a, input logic [23:0] w);
    i_pm_we = 1'b1; i_pm_waddr = a; i_pm_wdata = w;
    mem_model[a] = w;
    cyc();
    i_pm_we = 1'b0;
  endtask

  task automatic expect_prog(input logic [7:0] pc0);
    logic [7:0] pc;
    pc = pc0;
    for (int k = 0; k < 256; k++) begin
      if (mem_model[pc][23:20] == 4'hF) break;
      sb.push_back(mem_model[pc]);
      pc = pc + 8'd1;
    end
  endtask

  task automatic run_start(input logic [7:0] pc0);
    i_start = 1'b1; i_start_pc = pc0;
    cyc();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int k = 0; k < bound; k++) begin
      if (o_done) break;
      cyc();
    end
    check("done_reached", {31'h0, o_done}, 32'd1);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    cyc();
    i_rst = 1'b0;
    clear_sb();
  endtask

  task automatic load_hold_prog();
    load(8'h00, 24'h11EE01); load(8'h01, 24'h22EE02); load(8'h02, 24'h33EE03);
    load(8'h03, 24'h44EE04); load(8'h04, 24'h55EE05); load(8'h05, 24'hF00000);
  endtask

  initial begin
    int hs, hc;
    i_rst = 1'b1; i_pm_we = 1'b0; i_pm_waddr = 8'h00; i_pm_wdata = 24'h0;
    i_start = 1'b0; i_start_pc = 8'h00; i_hold = 1'b0;
    clear_sb();
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;

    check("rst_fields", {8'h0, fields()}, 32'h003000FF);
    check("rst_valid", {31'h0, o_issue_valid}, 32'd0);
    check("rst_busy_done", {30'h0, o_busy, o_done}, 32'd0);
    check("rst_cnts", {o_issue_cnt, o_stall_cnt}, 32'd0);

    // Basic program: two issues back to back, then halt.
    load(8'h00, 24'h012300); load(8'h01, 24'h1456FF); load(8'h02, 24'hF00000);
    expect_prog(8'h00);
    run_start(8'h00);
    wait_done(40);
    cyc(); cyc();
    check("basic_issue_cnt", {16'h0, o_issue_cnt}, 32'd2);
    check("basic_gap", max_gap, 32'd0);
    check("basic_stall_cnt", {16'h0, o_stall_cnt}, 32'd0);
    check("basic_busy", {31'h0, o_busy}, 32'd0);
    check("basic_sb_empty", sb.size(), 32'd0);

    // Dependent pair: rs1 of the second word equals rd of the first.
`ifdef HAZARD_CHK_EN
    exp_gap = 2; exp_stall = 2;
`else
    exp_gap = 0; exp_stall = 0;
`endif
    do_reset();
    load(8'h00, 24'h0512AA); load(8'h01, 24'h0651BB); load(8'h02, 24'hF00000);
    expect_prog(8'h00);
    run_start(8'h00);
    wait_done(40);
    check("haz_gap", max_gap, exp_gap);
    check("haz_stall_cnt", {16'h0, o_stall_cnt}, exp_stall);
    check("haz_issue_cnt", {16'h0, o_issue_cnt}, 32'd2);
    check("haz_sb_empty", sb.size(), 32'd0);

    // Hold for 3 cycles mid-program; a write attempted while running must be ignored.
    do_reset();
    load_hold_prog();
    expect_prog(8'h00);
    run_start(8'h00);
    hs = 0; hc = 0;
    for (int k = 0; k < 60; k++) begin
      cyc();
      if (o_done) break;
      if (hs == 0 && n_iss == 2) begin
        i_hold = 1'b1; i_pm_we = 1'b1; i_pm_waddr = 8'h04; i_pm_wdata = 24'h7EEEEE;
        hs = 1; hc = 0;
      end else if (hs == 1) begin
        i_pm_we = 1'b0;
        hc++;
        if (hc == 3) begin
          i_hold = 1'b0;
          hs = 2;
        end
      end
    end
    check("hold_done", {31'h0, o_done}, 32'd1);
    check("hold_gap", max_gap, 32'd3);
    check("hold_stall_cnt", {16'h0, o_stall_cnt}, 32'd3);
    check("hold_issue_cnt", {16'h0, o_issue_cnt}, 32'd5);
    check("hold_sb_empty", sb.size(), 32'd0);

    // pc wrap from 0xFF to 0x00.
    do_reset();
    load(8'hFF, 24'h1ABCDE); load(8'h00, 24'h2DEF11); load(8'h01, 24'hF00000);
    expect_prog(8'hFF);
    run_start(8'hFF);
    wait_done(40);
    check("wrap_issue_cnt", {16'h0, o_issue_cnt}, 32'd2);
    check("wrap_gap", max_gap, 32'd0);
    check("wrap_sb_empty", sb.size(), 32'd0);

    // Reset mid-run (with start asserted alongside), then re-execute.
    do_reset();
    load_hold_prog();
    expect_prog(8'h00);
    run_start(8'h00);
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (n_iss >= 2) break;
    end
    check("midrst_reached", n_iss, 32'd2);
    i_rst = 1'b1; i_start = 1'b1;
    cyc();
    i_rst = 1'b0; i_start = 1'b0;
    check("midrst_fields", {8'h0, fields()}, 32'h003000FF);
    check("midrst_valid", {31'h0, o_issue_valid}, 32'd0);
    check("midrst_busy_done", {30'h0, o_busy, o_done}, 32'd0);
    check("midrst_cnts", {o_issue_cnt, o_stall_cnt}, 32'd0);
    clear_sb();
    expect_prog(8'h00);
    run_start(8'h00);
    wait_done(40);
    check("rerun_issue_cnt", {16'h0, o_issue_cnt}, 32'd5);
    check("rerun_sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
